asin_seq: RTL and testbench
===========================

ASIN_SEQ -- requirements
Module: asin_seq

Interface
REQ-001 SHALL have parameter ITER, default 14, meaning the number of bisection steps; ITER SHALL be at least 14.
REQ-002 SHALL have parameter MAX_ANG, default 9000, meaning the upper angle bound in 0.01-degree units.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request, accepted only in IDLE.
REQ-006 SHALL have port sin_in, input, 16 bits: signed two's-complement sine value scaled by 10000.
REQ-007 SHALL have port angle, output, 16 bits: signed arcsine in 0.01-degree units.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: a one-cycle pulse when angle and err are valid.
REQ-010 SHALL have port err, output, 1 bit: input out of range; valid with done.

Function
REQ-011 SHALL have FSM states IDLE, SEARCH and DONE.
REQ-012 IDLE SHALL go to SEARCH when start=1; this SHALL register sign = sin_in[15], m = |sin_in|, lo = 0, hi = MAX_ANG and iter = 0.
REQ-013 IDLE SHALL go straight to DONE when start=1 and |sin_in| > 10000; this SHALL set err=1 and angle=0.
REQ-014 Each SEARCH cycle SHALL compute mid = (lo+hi+1)>>1; if s(mid) <= m then lo = mid, else hi = mid-1.
REQ-015 Once lo==hi, further SEARCH steps SHALL leave lo and hi unchanged.
REQ-016 SEARCH SHALL go to DONE after exactly ITER steps.
REQ-017 DONE SHALL drive angle = sign ? -lo : lo and done=1 for one cycle, then return to IDLE.
REQ-018 Latency SHALL be ITER+1 cycles from start sampled high to done high; an out-of-range input SHALL give done in the next cycle.
REQ-019 angle and err SHALL hold their values until the next done.
REQ-020 start while busy SHALL be ignored, with no effect on the in-flight search.
REQ-021 sin_in = -32768 SHALL be treated as out of range; the magnitude calculation SHALL not overflow.
REQ-022 s(a) SHALL be computed with a in 0..MAX_ANG:
- r = (a*31416)/18000
- s = r - r^3/(6*10^8) + r^5/(120*10^16) - r^7/(5040*10^24)
- each term truncated toward zero
- unsigned intermediates at least 100 bits wide
- result clamped to 0..10000
REQ-023 The result SHALL be the largest a in 0..MAX_ANG with s(a) <= m; since s(0) = 0, a result always exists.

Reset
REQ-024 rst=1 SHALL force IDLE and clear angle, done, err, busy, lo, hi and iter to 0, including when asserted mid-search.
REQ-025 start SHALL be ignored in any cycle where rst=1.

Configuration
REQ-026 With ASIN_ACOS_EN defined, the block SHALL add output acos_out (16 bits, signed) = 9000 - angle, updated with done and reset to 0.
REQ-027 Without ASIN_ACOS_EN, acos_out SHALL not exist, and behaviour SHALL be otherwise identical.

Structure
REQ-028 Package calc_pkg SHALL hold:
- SCALE = 10000
- PI_X1E4 = 31416
- DEG_X100_180 = 18000
- MAX_ANG default
- the FSM state enum
REQ-029 s(a) SHALL be a combinational sub-module sin_poly (input 14-bit angle, output 14-bit sine), instantiated once.

Verification
REQ-030 sin_in=0, start pulse -> done at cycle 15, angle=0, err=0.
REQ-031 sin_in=5000 -> angle = 3000±2, bit-exact to the bench model of REQ-022/023; sin_in=-5000 -> the exact negation.
REQ-032 sin_in=10000 -> angle = 9000±2, equal to the model; sin_in=-10000 -> its negation.
REQ-033 sin_in=10001 and sin_in=-32768 -> done one cycle after start, err=1, angle=0.
REQ-034 start mid-search is ignored; rst at search step 7 -> all outputs 0 next cycle and no done pulse; a new start then completes normally.
REQ-035 Exhaustive sweep of sin_in over -10000..10000 SHALL match the model, with done count equal to start count.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and FSM state type for the arcsine sequencer
package calc_pkg;
   localparam int SCALE = 10000;
   localparam int PI_X1E4 = 31416;
   localparam int DEG_X100_180 = 18000;
   localparam int MAX_ANG_DEFAULT = 9000;
   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
endpackage

// File: rtl/sin_poly.sv
// sin_poly: combinational 7th-order Taylor sine of an angle in 0.01-degree units, scaled by 10000
module sin_poly
   import calc_pkg::*;
(
   input  logic [13:0] a,
   output logic [13:0] s
);
   logic [127:0] r, r2, pos, neg, d;
   always_comb begin
      r = 128'(a) * 128'(PI_X1E4) / 128'(DEG_X100_180);
      r2 = r * r;
      pos = r + r * r2 * r2 / 128'd1200000000000000000;
      neg = r * r2 / 128'd600000000 + r * r2 * r2 * r2 / 128'd5040000000000000000000000000;
      d = pos - neg;
      // Positive and negative terms kept apart so the difference never wraps
      s = pos < neg ? 14'd0 : d > 128'(SCALE) ? 14'(SCALE) : d[13:0];
   end
endmodule

// File: rtl/asin_seq.sv
// asin_seq: sequential arcsine by bisection over sin_poly; ASIN_ACOS_EN adds the acos_out output
module asin_seq
   import calc_pkg::*;
#(
   parameter int ITER    = 14,
   parameter int MAX_ANG = MAX_ANG_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] sin_in,
   output logic [15:0] angle,
   output logic        busy,
   output logic        done,
   output logic        err
`ifdef ASIN_ACOS_EN
   ,
   output logic [15:0] acos_out
`endif
);
   localparam int IW = $clog2(ITER + 1);
   state_t state, state_n;
   logic [13:0] lo, hi, lo_n, hi_n, m, m_n, mid, s_mid;
   logic [14:0] sum;
   logic [IW-1:0] iter, iter_n;
   logic sign, sign_n, err_n, oor, last;
   logic [15:0] mag, angle_n;
   // -32768 negates to 0x8000, which reads as 32768 unsigned and lands out of range
   assign mag = sin_in[15] ? 16'(-sin_in) : sin_in;
   assign oor = mag > 16'(SCALE);
   assign sum = {1'b0, lo} + {1'b0, hi} + 15'd1;
   assign mid = sum[14:1];
   assign last = iter == IW'(ITER - 1);
   assign busy = state != IDLE;
   assign done = state == DONE;
   sin_poly u_poly (.a(mid), .s(s_mid));
   always_comb begin
      state_n = state;
      lo_n = lo;
      hi_n = hi;
      iter_n = iter;
      sign_n = sign;
      m_n = m;
      angle_n = angle;
      err_n = err;
      unique case (state)
         IDLE: if (start) begin
            sign_n = sin_in[15];
            m_n = mag[13:0];
            lo_n = '0;
            hi_n = 14'(MAX_ANG);
            iter_n = '0;
            state_n = oor ? DONE : SEARCH;
            angle_n = oor ? 16'd0 : angle;
            err_n = oor ? 1'b1 : err;
         end
         SEARCH: begin
            lo_n = lo != hi && s_mid <= m ? mid : lo;
            hi_n = lo != hi && s_mid > m ? mid - 14'd1 : hi;
            iter_n = iter + IW'(1);
            state_n = last ? DONE : SEARCH;
            angle_n = last ? (sign ? 16'd0 - {2'b00, lo_n} : {2'b00, lo_n}) : angle;
            err_n = last ? 1'b0 : err;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         lo <= '0;
         hi <= '0;
         iter <= '0;
         sign <= 1'b0;
         m <= '0;
         angle <= '0;
         err <= 1'b0;
      end else begin
         state <= state_n;
         lo <= lo_n;
         hi <= hi_n;
         iter <= iter_n;
         sign <= sign_n;
         m <= m_n;
         angle <= angle_n;
         err <= err_n;
      end
   end
`ifdef ASIN_ACOS_EN
   logic ld;
   assign ld = (state == IDLE && start && oor) || (state == SEARCH && last);
   always_ff @(posedge clk) acos_out <= rst ? 16'd0 : ld ? 16'd9000 - angle_n : acos_out;
`endif
endmodule

// File: tb/tb_asin_seq.sv
// tb_asin_seq: directed and random checks of asin_seq against a table-driven arcsine model
module tb_asin_seq;
   localparam int ITER = 14;
   localparam int MAXA = 9000;
   logic clk = 1'b0, rst, start;
   logic [15:0] sin_in, angle;
   logic busy, done, err;
`ifdef ASIN_ACOS_EN
   logic [15:0] acos_out;
`endif
   int n_chk = 0, n_fail = 0, ndone = 0, exp_done = 0;
   int s_tab[0:MAXA];

   asin_seq #(.ITER(ITER), .MAX_ANG(MAXA)) dut (
      .clk(clk), .rst(rst), .start(start), .sin_in(sin_in),
      .angle(angle), .busy(busy), .done(done), .err(err)
`ifdef ASIN_ACOS_EN
      , .acos_out(acos_out)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (done) ndone <= ndone + 1;

   function automatic int s_ref(int a);
      logic [127:0] r, p, q;
      r = 128'(a) * 128'd31416 / 128'd18000;
      p = r + r * r * r * r * r / (128'd120 * 128'd10000000000000000);
      q = r * r * r / (128'd6 * 128'd100000000)
        + r * r * r * r * r * r * r / (128'd5040 * 128'd1000000000000000000000000);
      if (p < q) return 0;
      return (p - q > 128'd10000) ? 10000 : int'(p - q);
   endfunction

   function automatic int model(int v);
      int mg, lo, hi, md;
      mg = v < 0 ? -v : v;
      lo = 0;
      hi = MAXA;
      repeat (ITER) if (lo < hi) begin
         md = (lo + hi + 1) / 2;
         if (s_tab[md] <= mg) lo = md;
         else hi = md - 1;
      end
      return v < 0 ? -lo : lo;
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic go(input int v, output int lat);
      @(negedge clk);
      sin_in = 16'(v);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 1;
      chk("busy after start", busy, 1);
      while (!done && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic run_chk(input int v, input string tag);
      int lat, ea;
      bit ee;
      ee = v > 10000 || v < -10000;
      ea = ee ? 0 : model(v);
      go(v, lat);
      exp_done++;
      chk({tag, " latency"}, lat, ee ? 1 : ITER + 1);
      chk({tag, " angle"}, $signed(angle), ea);
      chk({tag, " err"}, err, int'(ee));
`ifdef ASIN_ACOS_EN
      chk({tag, " acos"}, $signed(acos_out), 9000 - ea);
`endif
      @(posedge clk);
      #1 chk({tag, " done pulse"}, done, 0);
      chk({tag, " idle"}, busy, 0);
   endtask

   initial begin
      int lat, a5, a10;
      rst = 1'b1;
      start = 1'b1;
      sin_in = 16'd100;
      for (int a = 0; a <= MAXA; a++) s_tab[a] = s_ref(a);
      repeat (3) @(posedge clk);
      #1 chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst angle", $signed(angle), 0);
      chk("rst err", err, 0);
`ifdef ASIN_ACOS_EN
      chk("rst acos", $signed(acos_out), 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      run_chk(0, "zero");
      run_chk(5000, "p5000");
      a5 = $signed(angle);
      chk("p5000 near 3000", int'(a5 >= 2998 && a5 <= 3002), 1);
      run_chk(-5000, "n5000");
      chk("n5000 negation", $signed(angle), -a5);
      run_chk(10000, "p10000");
      a10 = $signed(angle);
      chk("p10000 near 9000", int'(a10 >= 8998 && a10 <= 9002), 1);
      run_chk(-10000, "n10000");
      chk("n10000 negation", $signed(angle), -a10);
      run_chk(10001, "oor 10001");
      run_chk(-32768, "oor min");
      run_chk(-10001, "oor -10001");
      // second start five cycles into a search must not disturb it
      @(negedge clk);
      sin_in = 16'(7071);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 1;
      repeat (5) begin
         @(posedge clk);
         #1 lat++;
      end
      @(negedge clk);
      sin_in = 16'(-3000);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat++;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      exp_done++;
      chk("busy start latency", lat, ITER + 1);
      chk("busy start angle", $signed(angle), model(7071));
      chk("busy start err", err, 0);
      repeat (20) @(posedge clk);
      #1 chk("busy start done count", ndone, exp_done);
      // reset sampled on the seventh search step aborts the search
      @(negedge clk);
      sin_in = 16'(2588);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 chk("abort angle", $signed(angle), 0);
      chk("abort err", err, 0);
      chk("abort done", done, 0);
      chk("abort busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1 chk("abort no done", ndone, exp_done);
      run_chk(2588, "after abort");
      for (int v = -10000; v <= 10000; v += 13) run_chk(v, "sweep");
      repeat (200) run_chk(int'($urandom_range(20000)) - 10000, "random");
      repeat (20) run_chk(int'($signed(16'($urandom()))), "random wide");
      repeat (3) @(posedge clk);
      #1 chk("total done count", ndone, exp_done);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
